ipsxe_floating_point_addsub_norm_64bit_v1_0: RTL
================================================

# ipsxe_floating_point_addsub_norm_64bit_v1_0

Post-adder normalize-and-round stage for the double-precision add/sub datapath. It takes the raw 64-bit significand sum, locates its leading one with the 64-bit leading-one finder, and then shifts and adjusts the exponent. It applies round-to-nearest-even and packs an IEEE-754 binary64 result with exception flags. It sits directly after the significand adder/subtractor and is the last stage before the add/sub output registers.

## Interface
- FIND_LATENCY, 0, register stages inside the leading-one finder (0..4), passed through to the sub-module.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_clken  in  1  pipeline enable; when low, every register holds.
- i_valid  in  1  input beat valid.
- i_sign  in  1  result sign, already resolved upstream, including the zero sign.
- i_exp  in  11  biased exponent for the weight of i_mant[62]. Upstream presents denormal operands with i_exp=1.
- i_mant  in  64  raw significand:
  - [63] carry-out position;
  - [62] hidden-bit position;
  - [61:10] fraction;
  - [9] guard;
  - [8:0] sticky field.
- i_nan, i_inf  in  1  special-case flags from upstream, carried with the beat.
- o_valid  out  1  result valid.
- o_result  out  64  packed binary64.
- o_overflow, o_underflow, o_inexact  out  1  exception flags, qualified by o_valid.

## Operation
- Zero detect: z = ~|i_mant. The finder returns 0 for a zero input, so z is carried as sideband.
- Let idx be the finder output (0..63).
- Right-shift case (idx==63):
  - mantissa >> 1;
  - old bit 0 ORs into the sticky field;
  - E' = i_exp+1.
- Left-shift case (idx<63):
  - L = 62-idx.
  - If i_exp-1 >= L: shift by L, E' = i_exp-L.
  - Otherwise (denormal): shift by i_exp-1, exponent field 0, tiny=1.
- Rounding (RNE):
  - lsb = m[10], g = m[9], s = |m[8:0];
  - up = g & (s|lsb);
  - inexact = g|s.
- Packing:
  - {exp_field, frac} = {E'(11b), m[61:10]} + up, using a 63-bit add.
  - A carry out of the fraction naturally bumps the exponent, so denormal→normal and 1.111..→2.0 need no special case.
- Overflow:
  - Condition: exp_field >= 2047 after rounding, or E' = 2047 from the right-shift case.
  - Result: {sign, 0x7FF, 0}, with o_overflow=1 and o_inexact=1.
- Underflow: o_underflow = tiny & inexact, where tiny means the result before rounding has exponent field 0.
- Output priority:
  - i_nan → 0x7FF8000000000000, all flags 0;
  - else i_inf → {sign, 0x7FF, 0}, flags 0;
  - else z → {sign, 63'b0}, flags 0;
  - else the normal path.

## Timing
- Latency: FIND_LATENCY+2 enabled cycles from i_valid to o_valid, one beat per cycle, no backpressure.
- Stage 0: the finder. i_sign, i_exp, i_mant, i_nan, i_inf, z and i_valid are delayed FIND_LATENCY cycles so they stay aligned with idx.
- Stage 1 (registered): shift plus exponent adjust, plus the tiny and sticky bits.
- Stage 2 (registered): round, pack and flags; this register drives all outputs.
- i_clken low: all stages, including the finder and the sideband delay, freeze; o_valid holds its value.
- Reset: on i_rst high at a clock edge, o_valid, o_result and all flags go to 0, and every pipeline valid clears. This happens regardless of i_clken. Beats in flight are dropped, and the first post-reset beat emerges after the full latency.
- The finder has an active-low asynchronous reset; it is driven with ~i_rst.
- Data registers may be reset; valid registers must be.

## Structure
- Shared package constants:
  - EXP_W=11, FRAC_W=52, BIAS=1023;
  - QNAN=64'h7FF8000000000000;
  - INF_EXP=11'h7FF;
  - mantissa field positions HID=62, LSB=10, GRD=9.
- Sub-module: ipsxe_floating_point_find_one_64bit_v1_0, with LATENCY=FIND_LATENCY.
- Everything else (sideband delay line, shifter, rounder) is inline.

## Test plan
- Basic normal, FIND_LATENCY=0: mant=1<<62, exp=1023, sign=0 → o_result=0x3FF0000000000000 exactly 2 cycles later, no flags.
- Carry and cancellation:
  - mant=1<<63, exp=1023 → 0x4000000000000000.
  - mant=1<<40, exp=1023 (left shift 22) → 0x3E90000000000000.
- Denormal:
  - mant=1<<40, exp=10 → 0x0000008000000000, o_underflow=0 because the result is exact.
  - Adding bit 0 → same result, o_inexact=1, o_underflow=1.
- RNE:
  - (1<<62)|(1<<9) → 0x3FF0000000000000, o_inexact=1 (tie rounds to even).
  - (1<<62)|(1<<10)|(1<<9) → 0x3FF0000000000002.
- Overflow and specials:
  - mant=1<<63, exp=2046 → 0x7FF0000000000000, o_overflow=1.
  - i_nan=1 → 0x7FF8000000000000.
  - mant=0, sign=1 → 0x8000000000000000.
- Control, FIND_LATENCY=0..4:
  - Back-to-back beats with i_clken toggling: outputs appear in order, and latency counts enabled cycles only.
  - i_rst mid-stream: o_valid=0 on the next cycle, and no stale beat emerges afterwards.

Source files
------------

// File: rtl/ipsxe_floating_point_addsub_norm_64bit_v1_0_pkg.sv
// Shared constants and types for the double-precision add/sub normalize stage.
// Field positions refer to the 64-bit raw significand coming out of the
// significand adder: [63] carry-out, [62] hidden bit, [61:10] fraction,
// [9] guard, [8:0] sticky field.
package ipsxe_floating_point_addsub_norm_64bit_v1_0_pkg;

    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int BIAS   = 1023;

    localparam logic [63:0]      QNAN    = 64'h7FF8_0000_0000_0000;
    localparam logic [EXP_W-1:0] INF_EXP = 11'h7FF;

    localparam int HID = 62;
    localparam int LSB = 10;
    localparam int GRD = 9;

    // Sideband that travels alongside the leading-one finder. Bit 63 of the
    // significand is only needed by the finder itself, so it is not carried.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [HID:0]     mant;
        logic             nan;
        logic             inf;
        logic             zero;
    } beat_t;

endpackage

// File: rtl/ipsxe_floating_point_addsub_norm_64bit_v1_0_if.sv
// Beat bus between the significand adder and the add/sub output registers.
//   i_valid/i_sign/i_exp/i_mant/i_nan/i_inf : raw sum beat into the stage
//   o_valid/o_result/o_overflow/o_underflow/o_inexact : packed binary64 out
// slave  : the normalize stage (consumes i_*, produces o_*)
// master : the upstream/downstream side (produces i_*, consumes o_*)
interface ipsxe_floating_point_addsub_norm_64bit_v1_0_if;
    import ipsxe_floating_point_addsub_norm_64bit_v1_0_pkg::*;

    logic             i_valid;
    logic             i_sign;
    logic [EXP_W-1:0] i_exp;
    logic [63:0]      i_mant;
    logic             i_nan;
    logic             i_inf;

    logic             o_valid;
    logic [63:0]      o_result;
    logic             o_overflow;
    logic             o_underflow;
    logic             o_inexact;

    modport master (
        output i_valid, i_sign, i_exp, i_mant, i_nan, i_inf,
        input  o_valid, o_result, o_overflow, o_underflow, o_inexact
    );

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, i_nan, i_inf,
        output o_valid, o_result, o_overflow, o_underflow, o_inexact
    );

endinterface

// File: rtl/ipsxe_floating_point_addsub_norm_64bit_v1_0_find_one.sv
// 64-bit leading-one finder.
//   i_clk    : clock
//   i_rst_n  : asynchronous active-low reset for the output pipeline
//   i_clken  : pipeline enable, registers hold when low
//   i_data   : word to search
//   o_idx    : position of the most significant set bit (0 for a zero word),
//              delayed by LATENCY enabled cycles (0..4)
module ipsxe_floating_point_find_one_64bit_v1_0 #(
    parameter int LATENCY = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clken,
    input  logic [63:0] i_data,
    output logic [5:0]  o_idx
);

    logic [5:0] idx_c;

    always_comb begin
        idx_c = '0;
        for (int i = 0; i < 64; i++) begin
            if (i_data[i]) idx_c = 6'(i);
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign o_idx = idx_c;
        end else begin : g_pipe
            logic [5:0] idx_pipe [LATENCY];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < LATENCY; i++) idx_pipe[i] <= '0;
                end else if (i_clken) begin
                    idx_pipe[0] <= idx_c;
                    for (int i = 1; i < LATENCY; i++) idx_pipe[i] <= idx_pipe[i-1];
                end
            end

            assign o_idx = idx_pipe[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/ipsxe_floating_point_addsub_norm_64bit_v1_0.sv
// Post-adder normalize-and-round stage for the binary64 add/sub datapath.
// Finds the leading one of the raw significand sum, shifts it to the hidden
// position (or as far as the exponent allows for denormals), rounds to
// nearest-even and packs the result with overflow/underflow/inexact flags.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset (clears valids, outputs, flags)
//   i_clken : pipeline enable, every register holds when low
//   bus     : beat in (i_*) and packed result out (o_*), latency FIND_LATENCY+2
module ipsxe_floating_point_addsub_norm_64bit_v1_0
    import ipsxe_floating_point_addsub_norm_64bit_v1_0_pkg::*;
#(
    parameter int FIND_LATENCY = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clken,
    ipsxe_floating_point_addsub_norm_64bit_v1_0_if.slave bus
);

    function automatic logic rne_up(input logic lsb, input logic grd, input logic stk);
        return grd & (stk | lsb);
    endfunction

    // Exponent and fraction are added as one word so a fraction carry bumps
    // the exponent (denormal->normal, 1.11..1 -> 2.0) without a special case.
    function automatic logic [62:0] pack_sum(input logic [EXP_W-1:0] e,
                                             input logic [FRAC_W-1:0] f,
                                             input logic up);
        return {e, f} + {62'd0, up};
    endfunction

    beat_t      beat_in;
    beat_t      beat_p0;
    logic       vld_p0;
    logic [5:0] idx_p0;

    assign beat_in = '{sign: bus.i_sign, exp: bus.i_exp, mant: bus.i_mant[HID:0],
                       nan: bus.i_nan, inf: bus.i_inf, zero: ~|bus.i_mant};

    // ---- stage 0: leading-one finder, sideband delayed to stay aligned ----
    ipsxe_floating_point_find_one_64bit_v1_0 #(
        .LATENCY (FIND_LATENCY)
    ) u_find_one (
        .i_clk   (i_clk),
        .i_rst_n (~i_rst),
        .i_clken (i_clken),
        .i_data  (bus.i_mant),
        .o_idx   (idx_p0)
    );

    generate
        if (FIND_LATENCY == 0) begin : g_nodly
            assign beat_p0 = beat_in;
            assign vld_p0  = bus.i_valid;
        end else begin : g_dly
            beat_t                   sb_dly  [FIND_LATENCY];
            logic [FIND_LATENCY-1:0] vld_dly;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    vld_dly <= '0;
                end else if (i_clken) begin
                    vld_dly[0] <= bus.i_valid;
                    for (int i = 1; i < FIND_LATENCY; i++) vld_dly[i] <= vld_dly[i-1];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_clken) begin
                    sb_dly[0] <= beat_in;
                    for (int i = 1; i < FIND_LATENCY; i++) sb_dly[i] <= sb_dly[i-1];
                end
            end

            assign beat_p0 = sb_dly[FIND_LATENCY-1];
            assign vld_p0  = vld_dly[FIND_LATENCY-1];
        end
    endgenerate

    logic [HID-1:0]   mant_nx;
    logic [11:0]      exp_nx;
    logic             tiny_nx;
    logic             ovf_nx;
    logic [11:0]      exp_w;
    logic [11:0]      dnm_sh;
    logic [5:0]       lsh;

    always_comb begin
        exp_w   = {1'b0, beat_p0.exp};
        lsh     = 6'd62 - idx_p0;
        // Largest left shift the exponent can absorb while staying >= 1.
        dnm_sh  = (beat_p0.exp == '0) ? 12'd0 : exp_w - 12'd1;
        mant_nx = '0;
        exp_nx  = '0;
        tiny_nx = 1'b0;
        if (idx_p0 == 6'd63) begin
            // Carry-out: the old hidden bit becomes fraction MSB, the bit
            // falling off the bottom folds into the sticky field.
            mant_nx    = beat_p0.mant[HID:1];
            mant_nx[0] = beat_p0.mant[1] | beat_p0.mant[0];
            exp_nx     = exp_w + 12'd1;
        end else if (dnm_sh >= {6'd0, lsh}) begin
            mant_nx = beat_p0.mant[HID-1:0] << lsh;
            exp_nx  = exp_w - {6'd0, lsh};
        end else begin
            mant_nx = beat_p0.mant[HID-1:0] << dnm_sh[5:0];
            tiny_nx = 1'b1;
        end
        ovf_nx = (exp_nx >= 12'd2047);
    end

    // ---- stage 1: normalized significand and adjusted exponent ----
    logic             vld_p1;
    logic             sign_p1;
    logic             nan_p1;
    logic             inf_p1;
    logic             zero_p1;
    logic [EXP_W-1:0] exp_p1;
    logic [HID-1:0]   mant_p1;
    logic             tiny_p1;
    logic             ovf_p1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
        end else if (i_clken) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clken) begin
            sign_p1 <= beat_p0.sign;
            nan_p1  <= beat_p0.nan;
            inf_p1  <= beat_p0.inf;
            zero_p1 <= beat_p0.zero;
            exp_p1  <= exp_nx[EXP_W-1:0];
            mant_p1 <= mant_nx;
            tiny_p1 <= tiny_nx;
            ovf_p1  <= ovf_nx;
        end
    end

    logic        up_n;
    logic        inx_n;
    logic [62:0] sum_n;
    logic [63:0] res_n;
    logic        ovf_n;
    logic        unf_n;
    logic        inxf_n;

    always_comb begin
        up_n   = rne_up(mant_p1[LSB], mant_p1[GRD], |mant_p1[GRD-1:0]);
        inx_n  = mant_p1[GRD] | (|mant_p1[GRD-1:0]);
        sum_n  = pack_sum(exp_p1, mant_p1[HID-1:LSB], up_n);
        res_n  = {sign_p1, sum_n};
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        inxf_n = 1'b0;
        if (nan_p1) begin
            res_n = QNAN;
        end else if (inf_p1) begin
            res_n = {sign_p1, INF_EXP, {FRAC_W{1'b0}}};
        end else if (zero_p1) begin
            res_n = {sign_p1, 63'd0};
        end else if (ovf_p1 || (sum_n[62:FRAC_W] == INF_EXP)) begin
            res_n  = {sign_p1, INF_EXP, {FRAC_W{1'b0}}};
            ovf_n  = 1'b1;
            inxf_n = 1'b1;
        end else begin
            unf_n  = tiny_p1 & inx_n;
            inxf_n = inx_n;
        end
    end

    // ---- stage 2: rounded, packed result drives the outputs ----
    logic        vld_p2;
    logic [63:0] res_p2;
    logic        ovf_p2;
    logic        unf_p2;
    logic        inx_p2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            ovf_p2 <= 1'b0;
            unf_p2 <= 1'b0;
            inx_p2 <= 1'b0;
        end else if (i_clken) begin
            vld_p2 <= vld_p1;
            res_p2 <= res_n;
            ovf_p2 <= ovf_n;
            unf_p2 <= unf_n;
            inx_p2 <= inxf_n;
        end
    end

    assign bus.o_valid     = vld_p2;
    assign bus.o_result    = res_p2;
    assign bus.o_overflow  = ovf_p2;
    assign bus.o_underflow = unf_p2;
    assign bus.o_inexact   = inx_p2;

endmodule
